// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Byte-FIFO-fed UART transmitter producing 8N1 frames, LSB first.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          TXD
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_FC_W  = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_BAUD_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_FC_W-1:0]  c_FULL     = c_FC_W'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FC_W-1:0]   r_count;
    logic                r_overflow;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_CNT_W-1:0]  r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_txd;
    logic                w_txd_next;
    logic                w_pop;
    logic                w_push;
    logic                w_empty;
    logic                w_tick;
    logic [7:0]          w_fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
    logic                w_parity_next;
`endif

    assign w_empty     = (r_count == '0);
    assign full        = (r_count == c_FULL);
    assign w_push      = wr_en && !full;
    assign w_tick      = (r_baud == '0);
    assign w_fifo_head = r_mem[r_rd_ptr];

    assign busy        = (r_state != c_S_IDLE) || !w_empty;
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;
    assign TXD         = r_txd;

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FC_W'(1);
                2'b01:   r_count <= r_count - c_FC_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // State register and serializer datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
            r_baud  <= (r_state == c_S_IDLE || w_tick) ? c_BAUD_MAX : r_baud - c_CNT_W'(1);
            if (r_state == c_S_START) begin
                r_bit_idx <= '0;
            end else if (r_state == c_S_DATA && w_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_S_START;
                end
            end
            c_S_START: begin
                if (w_tick) begin
                    w_state_next = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_tick && r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = c_S_PARITY;
`else
                    w_state_next = c_S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: begin
                if (w_tick) begin
                    w_state_next = c_S_STOP;
                end
            end
`endif
            c_S_STOP: begin
                if (w_tick) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = c_S_START;
                    end else begin
                        w_state_next = c_S_IDLE;
                    end
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Output logic looks at next-state values so the registered TXD is aligned.
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = w_fifo_head;
        end else if (r_state == c_S_DATA && w_tick) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
`ifdef UART_TX_PARITY_EN
        w_parity_next = w_pop ? ^w_fifo_head : r_parity;
`endif
        case (w_state_next)
            c_S_START:  w_txd_next = 1'b0;
            c_S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: w_txd_next = w_parity_next;
`endif
            default:    w_txd_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
